// File: rtl/link_up_pkg.sv
// Shared types and helpers for the upstream link transmitter.
package link_up_pkg;

  typedef enum logic [1:0] {IDLE, SEND, STALL} state_t;

  function automatic int calc_cw(input int credits);
    return $clog2(credits + 1);
  endfunction

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/link_ddr_upstream_gen_if.sv
// Core-side and I/O-side signal bundle for link_ddr_upstream_gen.
// LINK_UP_PARITY_EN widens each io lane by one parity bit.
interface link_ddr_upstream_gen_if #(
  parameter int NUM_CH   = 2,
  parameter int CH_WIDTH = 8,
  parameter int PHASES   = 2,
  parameter int CREDITS  = 32
);
  import link_up_pkg::*;

  localparam int CW = calc_cw(CREDITS);
`ifdef LINK_UP_PARITY_EN
  localparam int LW = CH_WIDTH + 1;
`else
  localparam int LW = CH_WIDTH;
`endif

  logic [NUM_CH*CH_WIDTH*PHASES-1:0] core_data_i;
  logic                              core_valid_i;
  logic                              core_ready_o;
  logic [NUM_CH*LW-1:0]              io_data_o;
  logic [NUM_CH-1:0]                 io_valid_o;
  logic [NUM_CH-1:0]                 token_i;
  logic [NUM_CH*CW-1:0]              credit_o;
  logic                              err_o;

  modport master (
    input  core_data_i, core_valid_i, token_i,
    output core_ready_o, io_data_o, io_valid_o, credit_o, err_o
  );

  modport slave (
    output core_data_i, core_valid_i, token_i,
    input  core_ready_o, io_data_o, io_valid_o, credit_o, err_o
  );

endinterface

// File: rtl/link_up_credit_ctr.sv
// Per-channel beat credit counter: token refill, beat decrement, saturation.
module link_up_credit_ctr
  import link_up_pkg::*;
#(
  parameter int  CREDITS     = 32,
  parameter int  TOKEN_BEATS = 8,
  localparam int CW          = calc_cw(CREDITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          dec,
  input  logic          token,
  output logic [CW-1:0] count,
  output logic          nonzero,
  output logic          overflow
);

  localparam logic [CW:0] MAX = (CW+1)'(CREDITS);
  localparam logic [CW:0] TOK = (CW+1)'(TOKEN_BEATS);

  // One extra bit holds count+token before saturation.
  logic [CW:0] sum;

  assign sum      = {1'b0, count} + (token ? TOK : '0) - {{CW{1'b0}}, dec};
  assign overflow = sum > MAX;
  assign nonzero  = |count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= CW'(CREDITS);
    else if (clear || overflow)
      count <= CW'(CREDITS);
    else
      count <= sum[CW-1:0];
  end

endmodule

// File: rtl/link_ddr_upstream_gen.sv
// Upstream link transmitter: splits core words into PHASES beats over NUM_CH
// credit-gated channels. LINK_UP_PARITY_EN adds an even-parity MSB per lane.
module link_ddr_upstream_gen
  import link_up_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CH_WIDTH    = 8,
  parameter int PHASES      = 2,
  parameter int CREDITS     = 32,
  parameter int TOKEN_BEATS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  link_ddr_upstream_gen_if.master  bus
);

  localparam int CW = calc_cw(CREDITS);
`ifdef LINK_UP_PARITY_EN
  localparam int LW = CH_WIDTH + 1;
`else
  localparam int LW = CH_WIDTH;
`endif
  localparam int WW = NUM_CH * CH_WIDTH * PHASES;
  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

  state_t               state;
  logic [PW-1:0]        phase;
  logic [WW-1:0]        hold;
  logic [NUM_CH*LW-1:0] io_data;
  logic [NUM_CH*LW-1:0] beat;
  logic                 io_valid;
  logic                 err;
  logic [NUM_CH-1:0]    nz;
  logic [NUM_CH-1:0]    ovf;
  logic                 all_nz;
  logic                 issue;
  logic                 last;
  logic                 ready;
  logic                 accept;

  assign all_nz = &nz;
  assign issue  = (state != IDLE) && all_nz;
  assign last   = (phase == LAST);
  assign ready  = (state == IDLE) || (state == SEND && last && all_nz);
  assign accept = bus.core_valid_i && ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CH_WIDTH-1:0] d;
    assign d = hold[(int'(phase)*NUM_CH + c)*CH_WIDTH +: CH_WIDTH];
`ifdef LINK_UP_PARITY_EN
    assign beat[c*LW +: LW] = {even_parity(64'(d)), d};
`else
    assign beat[c*LW +: LW] = d;
`endif

    link_up_credit_ctr #(
      .CREDITS     (CREDITS),
      .TOKEN_BEATS (TOKEN_BEATS)
    ) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (1'b0),
      .dec      (issue),
      .token    (bus.token_i[c]),
      .count    (bus.credit_o[c*CW +: CW]),
      .nonzero  (nz[c]),
      .overflow (ovf[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      hold     <= '0;
      io_data  <= '0;
      io_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= err | (|ovf);
      case (state)
        IDLE: begin
          io_valid <= 1'b0;
          if (bus.core_valid_i) begin
            hold  <= bus.core_data_i;
            phase <= '0;
            state <= SEND;
          end
        end
        SEND, STALL: begin
          if (all_nz) begin
            io_valid <= 1'b1;
            io_data  <= beat;
            if (!last) begin
              phase <= phase + 1'b1;
              state <= SEND;
            end else if (accept) begin
              hold  <= bus.core_data_i;
              phase <= '0;
              state <= SEND;
            end else begin
              state <= IDLE;
            end
          end else begin
            io_valid <= 1'b0;
            state    <= STALL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.core_ready_o = ready;
  assign bus.io_data_o    = io_data;
  assign bus.io_valid_o   = {NUM_CH{io_valid}};
  assign bus.err_o        = err;

endmodule

// File: tb/tb_link_ddr_upstream_gen.sv
// Directed plus randomized bench for link_ddr_upstream_gen against a beat-queue model.
module tb_link_ddr_upstream_gen;
  import link_up_pkg::*;

  localparam int NUM_CH      = 2;
  localparam int CH_WIDTH    = 8;
  localparam int PHASES      = 2;
  localparam int CREDITS     = 32;
  localparam int TOKEN_BEATS = 8;
  localparam int CW          = calc_cw(CREDITS);
  localparam int WW          = NUM_CH * CH_WIDTH * PHASES;
`ifdef LINK_UP_PARITY_EN
  localparam int LW = CH_WIDTH + 1;
`else
  localparam int LW = CH_WIDTH;
`endif
  localparam int BW = NUM_CH * LW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  link_ddr_upstream_gen_if #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .PHASES(PHASES),
                             .CREDITS(CREDITS)) bus ();

  link_ddr_upstream_gen #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .PHASES(PHASES),
                          .CREDITS(CREDITS), .TOKEN_BEATS(TOKEN_BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  string cur_tag = "reset";

  // Reference model: beats still owed for the held word, plus credits.
  logic [BW-1:0] pend[$];
  int            mcred[NUM_CH];
  bit            mstall, merr, mvalid;
  logic [BW-1:0] mdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] beat_of(input logic [WW-1:0] w, input int p);
    logic [BW-1:0]       r;
    logic [CH_WIDTH-1:0] ch;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch = w[(p*NUM_CH + c)*CH_WIDTH +: CH_WIDTH];
`ifdef LINK_UP_PARITY_EN
      r[c*LW +: LW] = {^ch, ch};
`else
      r[c*LW +: LW] = ch;
`endif
    end
    return r;
  endfunction

  function automatic logic [NUM_CH*CW-1:0] cred_vec();
    logic [NUM_CH*CW-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*CW +: CW] = CW'(mcred[c]);
    return r;
  endfunction

  function automatic bit m_can();
    bit ok;
    ok = pend.size() > 0;
    for (int c = 0; c < NUM_CH; c++) if (mcred[c] == 0) ok = 0;
    return ok;
  endfunction

  function automatic bit m_rdy();
    return pend.size() == 0 || (pend.size() == 1 && m_can() && !mstall);
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int c = 0; c < NUM_CH; c++) mcred[c] = CREDITS;
    mstall = 0; merr = 0; mvalid = 0; mdata = '0;
  endtask

  task automatic check_out();
    chk({cur_tag, "_valid"},  64'(bus.io_valid_o), 64'({NUM_CH{mvalid}}));
    chk({cur_tag, "_data"},   64'(bus.io_data_o),  64'(mdata));
    chk({cur_tag, "_credit"}, 64'(bus.credit_o),   64'(cred_vec()));
    chk({cur_tag, "_err"},    64'(bus.err_o),      64'(merr));
  endtask

  task automatic cyc(input bit v, input logic [WW-1:0] d, input logic [NUM_CH-1:0] tok);
    bit can, acc;
    int n;
    @(negedge clk);
    bus.core_valid_i = v;
    bus.core_data_i  = d;
    bus.token_i      = tok;
    #1;
    chk({cur_tag, "_ready"}, 64'(bus.core_ready_o), 64'(m_rdy()));
    can = m_can();
    acc = v && m_rdy();
    @(posedge clk);
    mstall = !can && pend.size() > 0;
    if (can) begin
      mdata  = pend.pop_front();
      mvalid = 1;
    end else begin
      mvalid = 0;
    end
    if (acc) for (int p = 0; p < PHASES; p++) pend.push_back(beat_of(d, p));
    for (int c = 0; c < NUM_CH; c++) begin
      n = mcred[c] + (tok[c] ? TOKEN_BEATS : 0) - (can ? 1 : 0);
      if (n > CREDITS) begin
        n = CREDITS;
        merr = 1;
      end
      mcred[c] = n;
    end
    #1;
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.core_valid_i = 1'b0;
    bus.token_i      = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.core_ready_o), 64'(1));
    check_out();
  endtask

  initial begin
    int nacc, vcount;
    bit tok_done;
    logic [NUM_CH-1:0] tok;

    bus.core_valid_i = 1'b0;
    bus.core_data_i  = '0;
    bus.token_i      = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", 64'(bus.core_ready_o), 64'(1));
    check_out();

    // Single word
    cur_tag = "single";
    cyc(1, WW'(32'hDDCC_BBAA), '0);
    cyc(0, '0, '0);
`ifndef LINK_UP_PARITY_EN
    chk("single_beat0", 64'(bus.io_data_o), 64'h0000_BBAA);
`endif
    cyc(0, '0, '0);
`ifndef LINK_UP_PARITY_EN
    chk("single_beat1", 64'(bus.io_data_o), 64'h0000_DDCC);
`endif
    cyc(0, '0, '0);
    chk("single_credit30", 64'(bus.credit_o[CW-1:0]), 64'(30));

    // Back-to-back
    do_reset();
    cur_tag = "b2b";
    nacc = 0; vcount = 0;
    for (int i = 0; i < 30 && nacc < 4; i++) begin
      if (m_rdy()) nacc++;
      cyc(1, WW'($urandom), '0);
      vcount += int'(bus.io_valid_o[0]);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, '0);
      vcount += int'(bus.io_valid_o[0]);
    end
    chk("b2b_beats", 64'(vcount), 64'(4*PHASES));
    chk("b2b_credit24", 64'(bus.credit_o[CW-1:0]), 64'(24));

    // Credit exhaustion
    do_reset();
    cur_tag = "exhaust";
    nacc = 0;
    for (int i = 0; i < 80 && nacc < 17; i++) begin
      if (m_rdy()) nacc++;
      cyc(1, WW'($urandom), '0);
    end
    chk("exhaust_accepts", 64'(nacc), 64'(17));
    repeat (3) cyc(0, '0, '0);
    chk("exhaust_stall_valid", 64'(bus.io_valid_o), 64'(0));
    chk("exhaust_credit0", 64'(bus.credit_o[CW-1:0]), 64'(0));
    cyc(0, '0, '1);
    chk("exhaust_token_credit8", 64'(bus.credit_o[CW-1:0]), 64'(8));
    cyc(0, '0, '0);
    chk("exhaust_resume_valid", 64'(bus.io_valid_o), 64'({NUM_CH{1'b1}}));
    chk("exhaust_credit7", 64'(bus.credit_o[CW-1:0]), 64'(7));
    repeat (3) cyc(0, '0, '0);

    // Simultaneous token and beat at credit 10
    do_reset();
    cur_tag = "tokbeat";
    tok_done = 0;
    for (int i = 0; i < 40 && !tok_done; i++) begin
      tok = (mcred[0] == 10 && m_can()) ? '1 : '0;
      cyc(1, WW'($urandom), tok);
      if (tok != '0) begin
        tok_done = 1;
        chk("tokbeat_credit17", 64'(bus.credit_o[CW-1:0]), 64'(17));
      end
    end
    chk("tokbeat_reached", 64'(tok_done), 64'(1));
    repeat (3) cyc(0, '0, '0);

    // Overflow at full credit
    do_reset();
    cur_tag = "ovf";
    cyc(0, '0, '1);
    chk("ovf_credit32", 64'(bus.credit_o[CW-1:0]), 64'(32));
    chk("ovf_err_set", 64'(bus.err_o), 64'(1));
    repeat (3) cyc(0, '0, '0);
    chk("ovf_err_sticky", 64'(bus.err_o), 64'(1));
    do_reset();
    chk("ovf_err_cleared", 64'(bus.err_o), 64'(0));

    // Randomized traffic and tokens
    cur_tag = "rand";
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) tok[c] = ($urandom_range(0, 5) == 0);
      cyc($urandom_range(0, 3) != 0, WW'($urandom), tok);
    end
    repeat (4) cyc(0, '0, '0);

    // Reset between phase 0 and phase 1
    do_reset();
    cur_tag = "midrst";
    cyc(1, WW'($urandom), '0);
    cyc(0, '0, '0);
    chk("midrst_phase0_valid", 64'(bus.io_valid_o), 64'({NUM_CH{1'b1}}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_async", 64'(bus.io_valid_o), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", 64'(bus.core_ready_o), 64'(1));
    check_out();
    repeat (3) cyc(0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
